// File: rtl/arith_pkg.sv
// Shared types for the sequential arithmetic unit: Y-select modes and FSM states.
package arith_pkg;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'b00,
    MODE_NEG  = 2'b01,
    MODE_ZERO = 2'b10,
    MODE_ONES = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/arith_slice.sv
// Combinational SLICE-bit adder: selects Y from B per mode, runs the ~B+1
// negate chain alongside the ripple carry, and exposes the carry into the MSB.
module arith_slice
  import arith_pkg::*;
#(
  parameter int SLICE = 2
) (
  input  logic [SLICE-1:0] a_s,
  input  logic [SLICE-1:0] b_s,
  input  mode_e            mode,
  input  logic             c_in,
  input  logic             n_in,
  output logic [SLICE-1:0] sum_s,
  output logic             c_out,
  output logic             n_out,
  output logic             c_msb
);

  // Ripple Y-select, negate chain and sum across the slice bits.
  always_comb begin
    logic c;
    logic n;
    logic y;
    c     = c_in;
    n     = n_in;
    y     = 1'b0;
    c_msb = c_in;
    sum_s = '0;
    for (int i = 0; i < SLICE; i++) begin
      unique case (mode)
        MODE_ADD:  y = b_s[i];
        MODE_NEG: begin
          y = ~b_s[i] ^ n;
          n = ~b_s[i] & n;
        end
        MODE_ZERO: y = 1'b0;
        default:   y = 1'b1;
      endcase
      if (i == SLICE - 1) c_msb = c;
      sum_s[i] = a_s[i] ^ y ^ c;
      c        = (a_s[i] & y) | (c & (a_s[i] ^ y));
    end
    c_out = c;
    n_out = n;
  end

endmodule

// File: rtl/arith_unit_seq.sv
// Multi-cycle D = A + Y + Cin, processed SLICE bits per cycle LSB first,
// with valid/ready handshakes and cout/zero/ovf flags.
//
// state | meaning
// IDLE  | in_ready=1, waiting for operands
// RUN   | one slice per cycle, NSLICE cycles
// DONE  | out_valid=1, result and flags held until out_ready
module arith_unit_seq
  import arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             cout,
  output logic             zero,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if (WIDTH < 2 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_param_check
    $error("arith_unit_seq: WIDTH must be >= 2 and a multiple of SLICE >= 1");
  end

  state_e           state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r, d_sh, sh_nxt, sum_ext;
  mode_e            mode_r;
  logic             carry, ncarry;
  logic [KW-1:0]    k;
  logic             last, load;
  logic [SLICE-1:0] sum_s;
  logic             c_out, n_out, c_msb;

  arith_slice #(.SLICE(SLICE)) u_slice (
    .a_s   (a_r[SLICE-1:0]),
    .b_s   (b_r[SLICE-1:0]),
    .mode  (mode_r),
    .c_in  (carry),
    .n_in  (ncarry),
    .sum_s (sum_s),
    .c_out (c_out),
    .n_out (n_out),
    .c_msb (c_msb)
  );

  assign last    = (state == RUN) && (k == KW'(NSLICE - 1));
  assign load    = (state == IDLE) && in_valid && !clr;
  // New sum slice enters at the top; after NSLICE shifts the result is aligned.
  assign sum_ext = WIDTH'(sum_s);
  assign sh_nxt  = (d_sh >> SLICE) | (sum_ext << (WIDTH - SLICE));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs; clr overrides every transition.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN:  if (last) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  // Operand capture, per-slice shifting, and result/flag update on the last slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      mode_r <= MODE_ADD;
      carry  <= 1'b0;
      ncarry <= 1'b0;
      k      <= '0;
      d_sh   <= '0;
      d      <= '0;
      cout   <= 1'b0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
    end else if (load) begin
      a_r    <= a;
      b_r    <= b;
      mode_r <= mode_e'(mode);
      carry  <= cin;
      ncarry <= (mode == MODE_NEG);
      k      <= '0;
    end else if (state == RUN && !clr) begin
      a_r    <= a_r >> SLICE;
      b_r    <= b_r >> SLICE;
      carry  <= c_out;
      ncarry <= n_out;
      d_sh   <= sh_nxt;
      k      <= k + KW'(1);
      if (last) begin
        d    <= sh_nxt;
        cout <= c_out;
        ovf  <= c_msb ^ c_out;
        zero <= (sh_nxt == '0);
      end
    end
  end

endmodule
